hazard_controller: RTL and testbench

Pipeline hazard controller for the 5-stage IF/ID/EX/MEM/WB ARM-style core.
- Generates stall and flush enables for the pipeline registers.
- Generates EX-stage operand forwarding selects.
- Sequences pipeline freeze during multi-cycle data-memory accesses, with a timeout watchdog.
- Keeps saturating stall and flush statistics counters.
- Sits beside the datapath; consumes register selectors and control booleans from ID/EX/MEM/WB.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/forward_unit.sv | 22 ++
 rtl/hazard_controller.sv | 161 ++++++++++++++++
 tb/tb_hazard_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [3:0] PC_REG = 4'd15;

  // R15 reads the PC, never a pipelined result, so it can never match.
  function automatic logic reg_match(input logic [3:0] a, input logic [3:0] b);
    return (a == b) && (a != PC_REG);
  endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for one source operand; MEM beats WB.
module forward_unit
  import hazard_pkg::*;
(
  input  logic [3:0] src,
  input  logic [3:0] dest_mem,
  input  logic       regw_mem,
  input  logic [3:0] dest_wb,
  input  logic       regw_wb,
  output logic [1:0] fwd_sel
);

  always_comb begin
    fwd_sel = FWD_NONE;
    if (regw_mem && reg_match(src, dest_mem)) begin
      fwd_sel = FWD_MEM;
    end else if (regw_wb && reg_match(src, dest_wb)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stall/flush generation, forwarding selects,
// data-memory freeze sequencing with watchdog, and saturating statistics.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       regselector1_ID,
  input  logic [3:0]       regselector2_ID,
  input  logic             regUse1_ID,
  input  logic             regUse2_ID,
  input  logic [3:0]       regselector1_EX,
  input  logic [3:0]       regselector2_EX,
  input  logic [3:0]       regselectordest_EX,
  input  logic             regwBoolean_EX,
  input  logic             MemrBoolean_EX,
  input  logic             branchTaken_EX,
  input  logic [3:0]       regselectordest_MEM,
  input  logic             regwBoolean_MEM,
  input  logic             mem_req_MEM,
  input  logic             mem_ready,
  input  logic [3:0]       regselectordest_WB,
  input  logic             regwBoolean_WB,
  output logic             StallIF,
  output logic             StallID,
  output logic             StallEX,
  output logic             StallMEM,
  output logic             FlushID,
  output logic             FlushEX,
  output logic             FlushWB,
  output logic [1:0]       ForwardA_EX,
  output logic [1:0]       ForwardB_EX,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              timeout_set;
  logic              flush_evt;
  logic              load_use;
  logic [1:0]        fwd_a, fwd_b;

  forward_unit u_fwd_a (
    .src      (regselector1_EX),
    .dest_mem (regselectordest_MEM),
    .regw_mem (regwBoolean_MEM),
    .dest_wb  (regselectordest_WB),
    .regw_wb  (regwBoolean_WB),
    .fwd_sel  (fwd_a)
  );

  forward_unit u_fwd_b (
    .src      (regselector2_EX),
    .dest_mem (regselectordest_MEM),
    .regw_mem (regwBoolean_MEM),
    .dest_wb  (regselectordest_WB),
    .regw_wb  (regwBoolean_WB),
    .fwd_sel  (fwd_b)
  );

  assign ForwardA_EX = reset ? FWD_NONE : fwd_a;
  assign ForwardB_EX = reset ? FWD_NONE : fwd_b;

  assign load_use = MemrBoolean_EX && regwBoolean_EX &&
                    ((regUse1_ID && reg_match(regselector1_ID, regselectordest_EX)) ||
                     (regUse2_ID && reg_match(regselector2_ID, regselectordest_EX)));

  always_comb begin
    next_state  = state;
    wait_nxt    = wait_cnt;
    timeout_set = 1'b0;
    flush_evt   = 1'b0;
    StallIF     = 1'b0;
    StallID     = 1'b0;
    StallEX     = 1'b0;
    StallMEM    = 1'b0;
    FlushID     = 1'b0;
    FlushEX     = 1'b0;
    FlushWB     = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_req_MEM && !mem_ready) begin
            StallIF    = 1'b1;
            StallID    = 1'b1;
            StallEX    = 1'b1;
            StallMEM   = 1'b1;
            FlushWB    = 1'b1;
            next_state = MEM_WAIT;
            wait_nxt   = WAIT_W'(1);
          end else if (branchTaken_EX) begin
            FlushID   = 1'b1;
            FlushEX   = 1'b1;
            flush_evt = 1'b1;
          end else if (load_use) begin
            StallIF = 1'b1;
            StallID = 1'b1;
            FlushEX = 1'b1;
          end
        end
        MEM_WAIT: begin
          // Ready and watchdog expiry both release the freeze immediately;
          // pending branches are picked up in the following RUN cycle.
          if (mem_ready) begin
            next_state = RUN;
            wait_nxt   = '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            timeout_set = 1'b1;
            next_state  = RUN;
            wait_nxt    = '0;
          end else begin
            StallIF  = 1'b1;
            StallID  = 1'b1;
            StallEX  = 1'b1;
            StallMEM = 1'b1;
            FlushWB  = 1'b1;
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (timeout_set) begin
        mem_timeout <= 1'b1;
      end
      stall_cycles <= sat_inc(stall_cycles, StallID);
      flush_count  <= sat_inc(flush_count, flush_evt);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized self-checking bench for hazard_controller against a behavioural model.
module tb_hazard_controller;

  localparam int TO   = 6;
  localparam int CW   = 4;
  localparam int SAT  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    regselector1_ID, regselector2_ID;
  logic          regUse1_ID, regUse2_ID;
  logic [3:0]    regselector1_EX, regselector2_EX, regselectordest_EX;
  logic          regwBoolean_EX, MemrBoolean_EX, branchTaken_EX;
  logic [3:0]    regselectordest_MEM;
  logic          regwBoolean_MEM, mem_req_MEM, mem_ready;
  logic [3:0]    regselectordest_WB;
  logic          regwBoolean_WB;
  logic          StallIF, StallID, StallEX, StallMEM;
  logic          FlushID, FlushEX, FlushWB;
  logic [1:0]    ForwardA_EX, ForwardB_EX;
  logic          mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit m_wait;
  int m_wcnt;
  bit m_to;
  int m_stall;
  int m_flush;

  hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .regselector1_ID     (regselector1_ID),
    .regselector2_ID     (regselector2_ID),
    .regUse1_ID          (regUse1_ID),
    .regUse2_ID          (regUse2_ID),
    .regselector1_EX     (regselector1_EX),
    .regselector2_EX     (regselector2_EX),
    .regselectordest_EX  (regselectordest_EX),
    .regwBoolean_EX      (regwBoolean_EX),
    .MemrBoolean_EX      (MemrBoolean_EX),
    .branchTaken_EX      (branchTaken_EX),
    .regselectordest_MEM (regselectordest_MEM),
    .regwBoolean_MEM     (regwBoolean_MEM),
    .mem_req_MEM         (mem_req_MEM),
    .mem_ready           (mem_ready),
    .regselectordest_WB  (regselectordest_WB),
    .regwBoolean_WB      (regwBoolean_WB),
    .StallIF             (StallIF),
    .StallID             (StallID),
    .StallEX             (StallEX),
    .StallMEM            (StallMEM),
    .FlushID             (FlushID),
    .FlushEX             (FlushEX),
    .FlushWB             (FlushWB),
    .ForwardA_EX         (ForwardA_EX),
    .ForwardB_EX         (ForwardB_EX),
    .mem_timeout         (mem_timeout),
    .stall_cycles        (stall_cycles),
    .flush_count         (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int fwd_ref(input logic [3:0] src);
    if (src == 4'd15) return 0;
    if (regwBoolean_MEM && regselectordest_MEM == src) return 2;
    if (regwBoolean_WB && regselectordest_WB == src) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic clear_inputs();
    regselector1_ID = 0; regselector2_ID = 0; regUse1_ID = 0; regUse2_ID = 0;
    regselector1_EX = 0; regselector2_EX = 0; regselectordest_EX = 0;
    regwBoolean_EX = 0; MemrBoolean_EX = 0; branchTaken_EX = 0;
    regselectordest_MEM = 0; regwBoolean_MEM = 0; mem_req_MEM = 0; mem_ready = 0;
    regselectordest_WB = 0; regwBoolean_WB = 0;
  endtask

  // One clock: check outputs at the falling edge against the model, then
  // advance the model across the rising edge. Entered/left at posedge+1.
  task automatic cycle();
    logic [6:0] ctl;
    int  fa, fb;
    bit  lu, sid, flushed;
    @(negedge clk);
    ctl = '0; fa = 0; fb = 0; sid = 0; flushed = 0;
    if (reset) begin
      m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      fa = fwd_ref(regselector1_EX);
      fb = fwd_ref(regselector2_EX);
      lu = MemrBoolean_EX && regwBoolean_EX && regselectordest_EX != 4'd15 &&
           ((regUse1_ID && regselector1_ID == regselectordest_EX) ||
            (regUse2_ID && regselector2_ID == regselectordest_EX));
      if (!m_wait) begin
        if (mem_req_MEM && !mem_ready) begin
          ctl = 7'b1111_001; m_wait = 1; m_wcnt = 1;
        end else if (branchTaken_EX) begin
          ctl = 7'b0000_110; flushed = 1;
        end else if (lu) begin
          ctl = 7'b1100_010;
        end
      end else if (mem_ready) begin
        m_wait = 0; m_wcnt = 0;
      end else if (m_wcnt == TO) begin
        m_wait = 0; m_wcnt = 0; m_to = 1;
      end else begin
        ctl = 7'b1111_001; m_wcnt++;
      end
      sid = ctl[5];
    end
    check("ctl", 32'({StallIF, StallID, StallEX, StallMEM, FlushID, FlushEX, FlushWB}), 32'(ctl));
    check("fwdA", 32'(ForwardA_EX), fa);
    check("fwdB", 32'(ForwardB_EX), fb);
    check("stall_cycles", 32'(stall_cycles), m_stall);
    check("flush_count", 32'(flush_count), m_flush);
    check("mem_timeout", 32'(mem_timeout), 32'(reset ? 1'b0 : mem_to_prev()));
    if (!reset) begin
      if (sid && m_stall < SAT) m_stall++;
      if (flushed && m_flush < SAT) m_flush++;
    end
    to_prev = m_to;
    @(posedge clk);
    #1;
  endtask

  bit to_prev;
  function automatic bit mem_to_prev();
    return to_prev;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int hi_ready;
    clear_inputs();
    reset = 1'b1;
    to_prev = 0;
    m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0;
    @(posedge clk); #1;
    cycle();
    check("rst_ctl", 32'({StallIF, StallID, FlushEX, FlushWB, ForwardA_EX}), 0);
    reset = 1'b0;
    cycle();

    // Load-use: single bubble, then the load has moved on.
    MemrBoolean_EX = 1; regwBoolean_EX = 1; regselectordest_EX = 1;
    regUse1_ID = 1; regselector1_ID = 1;
    #1 check("lu_ctl", 32'({StallIF, StallID, FlushEX}), 3'b111);
    cycle();
    MemrBoolean_EX = 0;
    cycle();
    check("lu_cnt", 32'(stall_cycles), 1);
    clear_inputs();

    // Forwarding priority and R15 exclusion.
    regwBoolean_MEM = 1; regselectordest_MEM = 2; regwBoolean_WB = 1; regselectordest_WB = 2;
    regselector1_EX = 2;
    cycle();
    check("fwdA_mem", 32'(ForwardA_EX), 2);
    regselectordest_MEM = 15; regselectordest_WB = 15; regselector1_EX = 15;
    cycle();
    check("fwdA_r15", 32'(ForwardA_EX), 0);
    clear_inputs();

    // Branch overrides a simultaneous load-use.
    MemrBoolean_EX = 1; regwBoolean_EX = 1; regselectordest_EX = 3;
    regUse2_ID = 1; regselector2_ID = 3; branchTaken_EX = 1;
    #1 check("br_ctl", 32'({StallID, FlushID, FlushEX}), 3'b011);
    cycle();
    check("br_cnt", 32'(flush_count), 1);
    clear_inputs();

    // Three-cycle memory wait.
    reset = 1; cycle(); reset = 0;
    mem_req_MEM = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    mem_ready = 1;
    #1 check("mw_release", 32'({StallIF, StallID, StallEX, StallMEM, FlushWB}), 0);
    cycle();
    check("mw_cnt", 32'(stall_cycles), 3);
    clear_inputs();
    cycle();

    // Asynchronous reset mid-freeze (wait count 5), then watchdog expiry.
    mem_req_MEM = 1; mem_ready = 0;
    regwBoolean_MEM = 1; regselectordest_MEM = 3; regselector1_EX = 3;
    for (int i = 0; i < 5; i++) cycle();
    #2 reset = 1;
    #1 check("arst_ctl", 32'({StallIF, StallID, StallEX, StallMEM, FlushWB, ForwardA_EX}), 0);
    check("arst_cnt", 32'({stall_cycles, flush_count, mem_timeout}), 0);
    cycle();
    reset = 0;
    for (int i = 0; i < TO + 1; i++) cycle();
    check("to_set", 32'(mem_timeout), 1);
    clear_inputs();
    for (int i = 0; i < 3; i++) cycle();
    check("to_sticky", 32'(mem_timeout), 1);
    reset = 1; cycle(); reset = 0;
    check("to_clear", 32'(mem_timeout), 0);

    // Randomized traffic with phases of slow and fast memory.
    hi_ready = 1;
    for (int n = 0; n < 4000; n++) begin
      if (n % 60 == 0) hi_ready = $urandom_range(0, 1);
      reset               = ($urandom_range(0, 249) == 0);
      regselector1_ID     = rnd_reg();
      regselector2_ID     = rnd_reg();
      regUse1_ID          = $urandom_range(0, 1);
      regUse2_ID          = $urandom_range(0, 1);
      regselector1_EX     = rnd_reg();
      regselector2_EX     = rnd_reg();
      regselectordest_EX  = rnd_reg();
      regwBoolean_EX      = ($urandom_range(0, 3) != 0);
      MemrBoolean_EX      = $urandom_range(0, 1);
      branchTaken_EX      = ($urandom_range(0, 3) == 0);
      regselectordest_MEM = rnd_reg();
      regwBoolean_MEM     = $urandom_range(0, 1);
      mem_req_MEM         = ($urandom_range(0, 2) == 0);
      mem_ready           = hi_ready ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
      regselectordest_WB  = rnd_reg();
      regwBoolean_WB      = $urandom_range(0, 1);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
